// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scanner: segment patterns, digit limits
// and switch bit positions.
package sseg_pkg;

  // Active-low a..g in bits 0..6, dp (bit 7) off; entry 0 is the rightmost item.
  localparam logic [15:0][7:0] SEG_PATTERN = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] HEX_MAX = 4'd15;

  localparam int SW_EN  = 0;
  localparam int SW_UP  = 1;
  localparam int SW_CLR = 2;
  localparam int SW_HEX = 3;

  function automatic logic [3:0] digit_max(input logic hex);
    return hex ? HEX_MAX : BCD_MAX;
  endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational digit decoder: 4-bit value plus decimal point to an active-low
// cathode pattern.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dp_on,
  output logic [7:0] seg
);

  always_comb begin
    seg    = SEG_PATTERN[value];
    seg[7] = ~dp_on;
  end

endmodule

// File: rtl/updown_sseg_scan.sv
// Multi-digit BCD/hex up/down counter with time-multiplexed seven-segment output.
// Optional macro SSEG_BLANK_LEADING_ZERO_EN blanks leading zero digits above digit 0.
module updown_sseg_scan
  import sseg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] SW,
  output logic [7:0] SSEG_CA,
  output logic [7:0] SSEG_AN,
  output logic [3:0] LED
);

  localparam int TW  = $clog2(TICK_DIV);
  localparam int SCW = $clog2(SCAN_DIV);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW  = DIGITS * 4;

  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(DIGITS - 1);

  logic [3:0]     sw_meta_q, sw_meta_d;
  logic [3:0]     sw_sync_q, sw_sync_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [SCW-1:0] scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]  digit_idx_q, digit_idx_d;
  logic [CW-1:0]  count_q, count_d;
  logic           wrap_q, wrap_d;
  logic           hb_q, hb_d;
  logic [7:0]     ca_q, ca_d;
  logic [7:0]     an_q, an_d;

  logic           tick;
  logic [3:0]     dmax;
  logic [CW-1:0]  cnt_up, cnt_dn;
  logic           carry, borrow;
  logic [3:0]     cur_digit;
  logic           dp_on;
  logic           blank;
  logic [7:0]     seg_dec;

  // Counter path: both ripple results are built every cycle, then selected.
  always_comb begin
    sw_meta_d = SW;
    sw_sync_d = sw_meta_q;

    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    hb_d       = hb_q ^ tick;

    dmax   = digit_max(sw_sync_q[SW_HEX]);
    cnt_up = count_q;
    cnt_dn = count_q;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[i*4 +: 4] >= dmax) begin
          cnt_up[i*4 +: 4] = 4'd0;
        end else begin
          cnt_up[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[i*4 +: 4] == 4'd0) begin
          cnt_dn[i*4 +: 4] = dmax;
        end else if (count_q[i*4 +: 4] > dmax) begin
          cnt_dn[i*4 +: 4] = dmax;
          borrow           = 1'b0;
        end else begin
          cnt_dn[i*4 +: 4] = count_q[i*4 +: 4] - 4'd1;
          borrow           = 1'b0;
        end
      end
    end

    count_d = count_q;
    wrap_d  = wrap_q;
    if (sw_sync_q[SW_CLR]) begin
      count_d = '0;
      wrap_d  = 1'b0;
    end else if (tick && sw_sync_q[SW_EN]) begin
      if (sw_sync_q[SW_UP]) begin
        count_d = cnt_up;
        wrap_d  = wrap_q | carry;
      end else begin
        count_d = cnt_dn;
        wrap_d  = wrap_q | borrow;
      end
    end
  end

  // Scan path: pick the digit in the current slot and the matching anode.
  always_comb begin
    scan_cnt_d  = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
    end

    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx_q == IW'(i)) cur_digit = count_q[i*4 +: 4];
    end

    an_d = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if ((i < DIGITS) && (digit_idx_q == IW'(i))) an_d[i] = 1'b0;
    end

    dp_on = sw_sync_q[SW_HEX] && (digit_idx_q == '0);

`ifdef SSEG_BLANK_LEADING_ZERO_EN
    begin
      logic upper_zero;
      upper_zero = 1'b1;
      blank      = 1'b0;
      for (int i = DIGITS - 1; i > 0; i--) begin
        upper_zero = upper_zero && (count_q[i*4 +: 4] == 4'd0);
        if ((digit_idx_q == IW'(i)) && upper_zero) blank = 1'b1;
      end
    end
`else
    blank = 1'b0;
`endif
  end

  sseg_decode u_decode (
    .value (cur_digit),
    .dp_on (dp_on),
    .seg   (seg_dec)
  );

  always_comb begin
    ca_d = blank ? SEG_BLANK : seg_dec;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      tick_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      count_q     <= '0;
      wrap_q      <= 1'b0;
      hb_q        <= 1'b0;
      ca_q        <= SEG_BLANK;
      an_q        <= 8'hFF;
    end else begin
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      tick_cnt_q  <= tick_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      count_q     <= count_d;
      wrap_q      <= wrap_d;
      hb_q        <= hb_d;
      ca_q        <= ca_d;
      an_q        <= an_d;
    end
  end

  assign SSEG_CA = ca_q;
  assign SSEG_AN = an_q;
  assign LED     = {sw_sync_q[SW_UP], sw_sync_q[SW_EN], hb_q, wrap_q};

endmodule
